// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg -- shared definitions for the UART transmit arbiter.
//
// Contents:
//   arb_state_e       FSM state enumeration (IDLE, START, WAIT_DONE)
//   DATA_W_DEFAULT    default byte width
//   NUM_REQ_DEFAULT   default number of requesters
//   idx_width()       width of an index into n requesters (never below 1)
package uart_arb_pkg;

  localparam int DATA_W_DEFAULT  = 8;
  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if -- bundle of requester-side and transmitter-side signals
// of the UART transmit arbiter.
//
// Parameters: NUM_REQ requesters, DATA_W bits per byte.
// Signals:
//   req_valid   [NUM_REQ]         requester i has a byte pending
//   req_data    [NUM_REQ*DATA_W]  byte of requester i in [i*DATA_W +: DATA_W]
//   req_ready   [NUM_REQ]         one-cycle acknowledge of requester i
//   tx_start                      start pulse to the transmitter
//   tx_data     [DATA_W]          byte handed to the transmitter
//   tx_done                       transmitter frame-complete flag
//   busy                          arbiter is not idle
//   grant_id    [clog2(NUM_REQ)]  index of current/last granted requester
//   timeout_err                   one-cycle watchdog pulse
// Modports: master = arbiter side, slave = requesters/transmitter side.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT
);
  localparam int GID_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      busy;
  logic [GID_W-1:0]          grant_id;
  logic                      timeout_err;

  modport master (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_start, tx_data, busy, grant_id, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_start, tx_data, busy, grant_id, timeout_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin selector.
//
// Ports:
//   req        in  [NUM_REQ]  request vector
//   last_grant in  [IDX_W]    index granted last time
//   winner     out [IDX_W]    first requester at or after last_grant+1 (mod NUM_REQ)
//   any_valid  out 1          at least one request is set
// The search starts one past the previous winner, so the requester that was
// just served is always considered last.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  // Request vector rotated so that bit k corresponds to requester
  // (last_grant + 1 + k) mod NUM_REQ; the lowest set bit is then the winner.
  logic [NUM_REQ-1:0] rot_req;
  logic [IDX_W-1:0]   rot_idx [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot_idx[gi] = IDX_W'((int'(last_grant) + 1 + gi) % NUM_REQ);
      assign rot_req[gi] = req[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    winner    = '0;
    any_valid = |req;
    // Walk from the far end so the nearest (lowest k) hit is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        winner = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- shares one UART transmitter among NUM_REQ requesters.
//
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-low reset
//   bus    uart_tx_arbiter_if.master (requester handshake + transmitter side)
// Parameters:
//   NUM_REQ        number of requesters (2..8)
//   DATA_W         byte width
//   TIMEOUT_CYCLES watchdog limit in clk cycles
// Configuration macro:
//   UART_TX_ARB_TIMEOUT_EN  when defined, a watchdog aborts WAIT_DONE after
//                           TIMEOUT_CYCLES without a tx_done rising edge and
//                           pulses timeout_err; otherwise WAIT_DONE waits
//                           indefinitely and timeout_err is tied low.
//
// Flow: IDLE picks a winner round-robin and captures its byte, START drives
// tx_start and the winner's req_ready for one cycle, WAIT_DONE waits for a
// fresh rising edge of tx_done and then returns to IDLE.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEFAULT,
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.master  bus
);

  localparam int GID_W = idx_width(NUM_REQ);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_WAIT  = WAIT_DONE;

  logic [1:0]        state_reg, state_next;
  logic [DATA_W-1:0] tx_data_reg;
  logic [GID_W-1:0]  grant_id_reg;
  logic [GID_W-1:0]  last_grant_reg;
  logic              tx_done_prev_reg;

  logic [GID_W-1:0]  winner;
  logic              any_valid;
  logic [DATA_W-1:0] req_bytes [NUM_REQ];
  logic              grant_now;
  logic              done_rise;
  logic              timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_reg),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_bytes[gi] = bus.req_data[gi*DATA_W +: DATA_W];
      // Acknowledge only in START and only to the captured winner.
      assign bus.req_ready[gi] = (state_reg == ST_START) &&
                                 (grant_id_reg == GID_W'(gi));
    end
  endgenerate

  assign grant_now = (state_reg == ST_IDLE) && any_valid;

  // Only a 0->1 transition counts; a level left high by a previous frame
  // (or already high when tx_start goes out) keeps tx_done_prev_reg high.
  assign done_rise = bus.tx_done && !tx_done_prev_reg;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_reg;
  logic             timeout_err_reg;

  // wd_cnt_reg equals the number of completed WAIT_DONE cycles, so the
  // limit is reached on the TIMEOUT_CYCLES-th edge after entering WAIT_DONE.
  assign timeout_hit = (state_reg == ST_WAIT) && !done_rise &&
                       (wd_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= timeout_hit;
      if (state_reg == ST_START) begin
        wd_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.timeout_err = timeout_err_reg;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign bus.timeout_err    = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (any_valid) state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (done_rise || timeout_hit) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_IDLE;
      tx_data_reg      <= '0;
      grant_id_reg     <= '0;
      last_grant_reg   <= GID_W'(NUM_REQ - 1);
      tx_done_prev_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      tx_done_prev_reg <= bus.tx_done;
      // The byte is captured at selection time, so it is still sent even
      // if the requester withdraws req_valid before its req_ready.
      if (grant_now) begin
        tx_data_reg    <= req_bytes[winner];
        grant_id_reg   <= winner;
        last_grant_reg <= winner;
      end
    end
  end

  assign bus.tx_start = (state_reg == ST_START);
  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.tx_data  = tx_data_reg;
  assign bus.grant_id = grant_id_reg;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (legal 2..8).
REQ-002 SHALL have parameter DATA_W, default 8, byte width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536, watchdog limit in clk cycles (used only when UART_TX_ARB_TIMEOUT_EN is defined).
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  system clock, 50 MHz nominal
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a byte pending
- req_data  in  NUM_REQ*DATA_W  byte of requester i in slice [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-cycle acknowledge, byte of requester i accepted
- tx_start  out  1  start pulse to transmitter
- tx_data  out  DATA_W  byte to transmitter
- tx_done  in  1  transmitter frame-complete flag
- busy  out  1  high whenever state is not IDLE
- grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
- timeout_err  out  1  one-cycle watchdog pulse

Function
REQ-005 SHALL implement FSM states IDLE, START, WAIT_DONE.
REQ-006 IDLE: at a clock edge with any req_valid high, SHALL select winner round-robin starting at last_grant+1 (mod NUM_REQ), register req_data slice into tx_data, set grant_id, go START; otherwise stay IDLE.
REQ-007 START: tx_start and req_ready[grant_id] SHALL both be high for exactly one cycle; next state WAIT_DONE unconditionally.
REQ-008 tx_data SHALL be stable from START entry until the next grant.
REQ-009 WAIT_DONE: SHALL detect rising edge of tx_done (registered previous value) and return to IDLE on the following edge; level-high tx_done left over from a previous frame SHALL NOT end the wait.
REQ-010 Latency: req_valid sampled in IDLE -> tx_start 1 cycle later; tx_done rise -> IDLE 1 cycle later; back-to-back grants SHALL be separated by one IDLE cycle minimum.
REQ-011 last_grant SHALL update only on a grant; a requester just served SHALL have lowest priority next arbitration.
REQ-012 Single requester continuously valid SHALL be granted every frame without starvation; with all valid, grant order SHALL be 0,1,2,3,0,...
REQ-013 Requester SHALL hold req_valid/req_data stable until its req_ready; if req_valid drops after selection, the captured byte SHALL still be sent.
REQ-014 req_ready SHALL be one-hot or zero; never asserted outside START.
REQ-015 tx_start asserted with tx_done already high SHALL not be misinterpreted: only a later rising edge completes.

Reset
REQ-016 On reset low, asynchronously: state IDLE, tx_start 0, req_ready 0, tx_data 0, grant_id 0, busy 0, timeout_err 0, last_grant NUM_REQ-1, tx_done history 0, watchdog 0.
REQ-017 Reset asserted mid-frame SHALL abort to IDLE; no req_ready or tx_start issued for the aborted frame after release.
REQ-018 First grant after reset SHALL go to lowest-index valid requester.

Configuration
REQ-019 Macro UART_TX_ARB_TIMEOUT_EN defined: counter runs in WAIT_DONE; reaching TIMEOUT_CYCLES without tx_done rise SHALL pulse timeout_err one cycle and return to IDLE; counter clears on entering WAIT_DONE.
REQ-020 Macro undefined: no counter; WAIT_DONE waits indefinitely; timeout_err port present, tied 0.

Structure
REQ-021 Package uart_arb_pkg SHALL hold state enum (IDLE, START, WAIT_DONE) and DATA_W default constant.
REQ-022 Round-robin selection SHALL be sub-module rr_arbiter (combinational: req vector, last_grant -> winner index, any_valid).

Verification
REQ-023 Single request: req_valid=0001, data 0x55 -> tx_start 1 cycle later, tx_data=0x55, req_ready=0001 same cycle, busy until 1 cycle after tx_done rise.
REQ-024 All four valid, data 0x11/0x22/0x33/0x44 -> transmit order 0x11,0x22,0x33,0x44, grant_id 0,1,2,3.
REQ-025 Requesters 1 and 3 continuously valid -> grants alternate 1,3,1,3.
REQ-026 tx_done held high from prior frame at START -> arbiter stays in WAIT_DONE until tx_done falls and rises again.
REQ-027 Reset low during WAIT_DONE -> all outputs to reset values immediately; after release, req_valid=0100 -> grant_id 2.
REQ-028 Macro defined, TIMEOUT_CYCLES=100, tx_done never rises -> timeout_err pulse exactly 100 cycles after WAIT_DONE entry, then IDLE; macro undefined -> busy stays high.
